// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux with a bounded hold counter.
// Grant, select and hold count are registered; sel drives the mux S input.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             gnt_valid,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       others;
  logic [1:0]       w_idle;
  logic [1:0]       w_next;

  // First set bit of r searching upward from p+1, wrapping.
  function automatic logic [1:0] pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k) + 2'd1;
      if (r[idx]) pick = idx;
    end
  endfunction

  assign others = req & ~gnt_q;
  assign w_idle = pick(req, ptr_q);
  assign w_next = pick(others, sel_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << w_idle;
          sel_d   = w_idle;
          hold_d  = ONE_C;
        end
      end
      GRANT: begin
        if (!req[sel_q] || hold_q >= MAX_C) begin
          if (|others) begin
            ptr_d  = sel_q;
            gnt_d  = 4'b0001 << w_next;
            sel_d  = w_next;
            hold_d = ONE_C;
          end else if (!req[sel_q]) begin
            ptr_d   = sel_q;
            state_d = IDLE;
            gnt_d   = 4'b0000;
            hold_d  = '0;
          end else begin
            hold_d = MAX_C;
          end
        end else begin
          hold_d = hold_q + ONE_C;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign gnt_valid = (state_q == GRANT);
  assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (hold limits 8 and 1) checked
// against a behavioural model every cycle plus directed literal scenarios.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b;
  logic       vld_a, vld_b;
  logic [7:0] hold_a, hold_b;
  logic [3:0] mux_i;

  mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_a), .sel(sel_a),
    .gnt_valid(vld_a), .hold_cnt(hold_a)
  );

  mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_b), .sel(sel_b),
    .gnt_valid(vld_b), .hold_cnt(hold_b)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: owner (-1 idle), held cycles, last owner pointer, mux select.
  typedef struct {
    int own;
    int cnt;
    int ptr;
    int sel;
  } mdl_t;

  mdl_t m[2];
  int   mh[2] = '{8, 1};

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int i = 0; i < 4; i++) begin
      if (r[(start + i) % 4]) return (start + i) % 4;
    end
    return -1;
  endfunction

  function automatic mdl_t step(input mdl_t s, input logic [3:0] r, input int lim);
    mdl_t n = s;
    logic [3:0] oth;
    int w;
    if (s.own < 0) begin
      w = first_from(r, s.ptr + 1);
      if (w >= 0) begin n.own = w; n.cnt = 1; end
    end else if (!r[s.own]) begin
      n.ptr = s.own;
      w = first_from(r, s.own + 1);
      n.own = w;
      n.cnt = (w < 0) ? 0 : 1;
    end else if (s.cnt < lim) begin
      n.cnt = s.cnt + 1;
    end else begin
      oth = r;
      oth[s.own] = 1'b0;
      if (oth != 4'b0) begin
        n.ptr = s.own;
        n.own = first_from(oth, s.own + 1);
        n.cnt = 1;
      end else begin
        n.cnt = lim;
      end
    end
    if (n.own >= 0) n.sel = n.own;
    return n;
  endfunction

  function automatic mdl_t mreset();
    mdl_t r;
    r.own = -1; r.cnt = 0; r.ptr = 3; r.sel = 0;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= mreset();
      m[1] <= mreset();
    end else begin
      m[0] <= step(m[0], req, mh[0]);
      m[1] <= step(m[1], req, mh[1]);
    end
  end

  function automatic int egnt(input mdl_t s);
    return (s.own < 0) ? 0 : (1 << s.own);
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("a_gnt", int'(gnt_a), egnt(m[0]));
      chk("a_sel", int'(sel_a), m[0].sel);
      chk("a_vld", int'(vld_a), int'(m[0].own >= 0));
      chk("a_hold", int'(hold_a), m[0].cnt);
      chk("b_gnt", int'(gnt_b), egnt(m[1]));
      chk("b_sel", int'(sel_b), m[1].sel);
      chk("b_vld", int'(vld_b), int'(m[1].own >= 0));
      chk("b_hold", int'(hold_b), m[1].cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int exp_sel[5] = '{0, 1, 2, 3, 0};
  int exp_y[5]   = '{0, 1, 0, 1, 0};

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    mux_i = 4'b1010;
    m[0]  = mreset();
    m[1]  = mreset();

    // reset then single request
    do_reset();
    chk("rst_gnt", int'(gnt_a), 0);
    chk("rst_sel", int'(sel_a), 0);
    chk("rst_vld", int'(vld_a), 0);
    chk("rst_hold", int'(hold_a), 0);
    req = 4'b0001;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("single_gnt", int'(gnt_a), 1);
      chk("single_vld", int'(vld_a), 1);
      chk("single_hold", int'(hold_a), i);
    end
    req = 4'b0000;
    tick();
    chk("idle_gnt", int'(gnt_a), 0);
    chk("idle_hold", int'(hold_a), 0);
    chk("idle_sel", int'(sel_a), 0);

    // round robin with hold limit 1
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_sel", int'(sel_b), exp_sel[i]);
      chk("rr_y", int'(mux_i[sel_b]), exp_y[i]);
      chk("rr_gnt", int'(gnt_b), 1 << exp_sel[i]);
    end

    // hold limit then preempt
    do_reset();
    req = 4'b0001;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("lim_hold", int'(hold_a), i);
    end
    req = 4'b0101;
    for (int i = 4; i <= 8; i++) begin
      tick();
      chk("lim_gnt", int'(gnt_a), 1);
      chk("lim_hold", int'(hold_a), i);
    end
    tick();
    chk("pre_gnt", int'(gnt_a), 4);
    chk("pre_hold", int'(hold_a), 1);

    // saturation
    do_reset();
    req = 4'b0010;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("sat_gnt", int'(gnt_a), 2);
      chk("sat_hold", int'(hold_a), (i < 8) ? i : 8);
    end

    // handover without bubble
    do_reset();
    req = 4'b0010;
    tick();
    chk("ho_gnt0", int'(gnt_a), 2);
    req = 4'b1000;
    #3;
    chk("ho_vld_mid", int'(vld_a), 1);
    tick();
    chk("ho_gnt1", int'(gnt_a), 8);
    chk("ho_vld", int'(vld_a), 1);

    // async reset mid-grant
    do_reset();
    req = 4'b0100;
    repeat (5) tick();
    chk("ar_hold5", int'(hold_a), 5);
    chk("ar_gnt4", int'(gnt_a), 4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", int'(gnt_a), 0);
    chk("ar_sel", int'(sel_a), 0);
    chk("ar_hold", int'(hold_a), 0);
    chk("ar_vld", int'(vld_a), 0);
    req = 4'b0111;
    #1;
    rst_n = 1'b1;
    tick();
    chk("ar_first", int'(gnt_a), 1);

    // random traffic with sticky requests and rare resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
